// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART receiver.
`timescale 1ns/1ps
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Rounded clocks-per-tick so the tick rate lands closest to BAUD*OVERSAMPLE.
  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    int den;
    den = baud_rate * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversampling tick on each wrap.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 33
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == LAST);
  assign cnt_d  = o_tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with 16x oversampling; optional o_framing_error port
// is enabled by defining UART_RX_FRAMING_ERR_EN.
`timescale 1ns/1ps
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 5_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int DATA_BITS  = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_data_input,
  output logic                 o_done_bit,
  output logic [DATA_BITS-1:0] o_data_byte
`ifdef UART_RX_FRAMING_ERR_EN
  ,
  output logic                 o_framing_error
`endif
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TCW-1:0] MID_TICK  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);

  logic                 tick_raw;
  logic                 tick_q;
  logic [1:0]           sync_q;
  logic                 rx;
  rx_state_e            state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_d;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick_raw)
  );

  assign rx = sync_q[1];

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx) state_d = START;
      end
      START: begin
        if (tick_q) begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      DATA: begin
        if (tick_q) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            shift_d    = {rx, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
            else                       bit_cnt_d = bit_cnt_q + BCW'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      STOP: begin
        if (tick_q) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tick_q     <= 1'b0;
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      tick_q     <= tick_raw;
      sync_q     <= {sync_q[0], i_rx_data_input};
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  assign o_done_bit  = done_q;
  assign o_data_byte = data_q;

`ifdef UART_RX_FRAMING_ERR_EN
  logic ferr_q;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) ferr_q <= 1'b0;
    else         ferr_q <= ferr_d;
  end
  assign o_framing_error = ferr_q;
`else
  logic ferr_unused;
  assign ferr_unused = ferr_d;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven at the line rate, outputs checked at negedge.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam realtime BIT_NS = 104166.667;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       done;
  logic [7:0] data;
`ifdef UART_RX_FRAMING_ERR_EN
  logic       ferr;
  int         ferr_cnt = 0;
`endif

  int      n_checks = 0;
  int      n_pass   = 0;
  int      done_cnt = 0;
  int      wide_cnt = 0;
  logic    done_prev = 1'b0;
  realtime last_done_t = 0;

  always #100 clk = ~clk;

  uart_receiver dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_rx_data_input (rx),
    .o_done_bit      (done),
    .o_data_byte     (data)
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    .o_framing_error (ferr)
`endif
  );

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      last_done_t = $realtime;
      if (done_prev === 1'b1) wide_cnt++;
    end
    done_prev = done;
`ifdef UART_RX_FRAMING_ERR_EN
    if (ferr === 1'b1) ferr_cnt++;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("check %s ok: 0x%0h", tag, got);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input realtime bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
    rx = 1'b1;
    $display("frame 0x%02h stop=%0b bit_ns=%0.1f sent", b, stop_bit, bit_ns);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(BIT_NS * n);
    @(negedge clk);
  endtask

  int      base;
  realtime t0;

  initial begin
    repeat (5) @(negedge clk);
    check_eq("rst_done_in", {31'd0, done}, 32'd0);
    check_eq("rst_byte_in", {24'd0, data}, 32'h00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_done_out", {31'd0, done}, 32'd0);
    check_eq("rst_byte_out", {24'd0, data}, 32'h00);

    // Single frame 0x55 with latency window around 9.5 bit times.
    base = done_cnt;
    t0 = $realtime;
    send_frame(8'h55, 1'b1, BIT_NS);
    idle_bits(1);
    check_eq("f55_count", done_cnt - base, 32'd1);
    check_eq("f55_byte", {24'd0, data}, 32'h55);
    check_eq("f55_latency", {31'd0, (last_done_t - t0 > 990000.0) && (last_done_t - t0 < 1010000.0)}, 32'd1);

    // Back-to-back, no idle gap.
    base = done_cnt;
    send_frame(8'h00, 1'b1, BIT_NS);
    check_eq("b2b_first_count", done_cnt - base, 32'd1);
    check_eq("b2b_first_byte", {24'd0, data}, 32'h00);
    send_frame(8'hFF, 1'b1, BIT_NS);
    idle_bits(1);
    check_eq("b2b_total_count", done_cnt - base, 32'd2);
    check_eq("b2b_second_byte", {24'd0, data}, 32'hFF);

    // Short low glitch on an idle line.
    base = done_cnt;
    rx = 1'b0;
    #2000;
    rx = 1'b1;
    idle_bits(2);
    check_eq("glitch_count", done_cnt - base, 32'd0);
    check_eq("glitch_byte", {24'd0, data}, 32'hFF);

    // Frame with stop bit low.
    base = done_cnt;
`ifdef UART_RX_FRAMING_ERR_EN
    ferr_cnt = 0;
`endif
    send_frame(8'hA3, 1'b0, BIT_NS);
    idle_bits(2);
    check_eq("ferr_count", done_cnt - base, 32'd0);
    check_eq("ferr_byte", {24'd0, data}, 32'hFF);
`ifdef UART_RX_FRAMING_ERR_EN
    check_eq("ferr_pulses", ferr_cnt, 32'd1);
`endif

    // Reset in the middle of data bit 4 of 0x3C, then a clean 0xC5.
    base = done_cnt;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h3C >> i) & 8'h01;
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("midrst_byte", {24'd0, data}, 32'h00);
    rst = 1'b0;
    idle_bits(2);
    check_eq("midrst_count", done_cnt - base, 32'd0);
    check_eq("midrst_byte_after", {24'd0, data}, 32'h00);
    send_frame(8'hC5, 1'b1, BIT_NS);
    idle_bits(1);
    check_eq("c5_count", done_cnt - base, 32'd1);
    check_eq("c5_byte", {24'd0, data}, 32'hC5);

    // Baud mismatch +2.5 % and -2.5 %.
    base = done_cnt;
    send_frame(8'h96, 1'b1, BIT_NS / 1.025);
    idle_bits(1);
    check_eq("fast_count", done_cnt - base, 32'd1);
    check_eq("fast_byte", {24'd0, data}, 32'h96);
    base = done_cnt;
    send_frame(8'h69, 1'b1, BIT_NS);
    idle_bits(1);
    send_frame(8'h96, 1'b1, BIT_NS / 0.975);
    idle_bits(1);
    check_eq("slow_count", done_cnt - base, 32'd2);
    check_eq("slow_byte", {24'd0, data}, 32'h96);

    check_eq("done_width", wide_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver for 8N1 frames: an internal baud-tick generator produces a 16x-oversampling strobe from the system clock, and a receive state machine uses it to detect the start bit, sample eight data bits LSB-first and check the stop bit. It sits between the board RX pin and the byte consumer, delivering each byte with a one-cycle done pulse.

## Interface
- CLK_FREQ, 5_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate in bits/s.
- OVERSAMPLE, 16: ticks per bit.
- DATA_BITS, 8: data bits per frame.
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_rx_data_input  in  1  serial line; idle high.
- o_done_bit  out  1  one-cycle pulse when a valid frame is received.
- o_data_byte  out  DATA_BITS  last received byte; held until the next valid frame.

## Operation
- Tick generator: counter 0..DIV-1, where DIV = round(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), giving 33 at defaults. It emits a 1-cycle tick when the counter wraps.
- The tick is registered once before the state machine uses it.
- i_rx_data_input passes through a 2-flop synchronizer. Only the synchronized value is used.
- States:
  - IDLE: tick counter held at 0. A synchronized low moves to START.
  - START: count ticks. At tick 7, i.e. mid-bit:
    - line low: clear the counter and go to DATA.
    - line high: glitch; return to IDLE, no output.
  - DATA: every 16 ticks, sample the line and shift it into the MSB of the shift register. The shift is a right shift, so the first bit lands in the LSB after DATA_BITS shifts. After DATA_BITS samples, go to STOP.
  - STOP: after 16 ticks, sample the line.
    - high: load o_data_byte from the shift register and pulse o_done_bit.
    - low: framing error; o_data_byte unchanged, no pulse.
    - Either way, return to IDLE.
- Back-to-back frames: a start edge seen in IDLE immediately after STOP is accepted. No idle gap is required.

## Timing
- Reset values: o_done_bit=0, o_data_byte=0, state IDLE, all counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. The block resumes in IDLE after release.
- o_done_bit is high for exactly one i_clock cycle. It asserts about 9.5 bit times plus 3 clocks after the start-bit falling edge (≈990 µs at defaults).
- o_data_byte updates on the same edge that o_done_bit rises, and is stable afterwards.
- Tolerated baud mismatch: ±3 %.

## Configuration
- UART_RX_FRAMING_ERR_EN defined: adds output o_framing_error (1 bit, reset 0). It pulses for one cycle when the stop bit samples low.
- Undefined: the port is absent and bad frames are silently dropped.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - the OVERSAMPLE default;
  - the divisor-computation function.
- Sub-module uart_baud_tick contains the divisor counter and the tick output, with i_clock and i_reset. The top level instantiates it and contains the synchronizer and the FSM.

## Test plan
- Reset, then frame 0x55: 9600 baud, LSB first, stop high. Required: o_done_bit pulses once and o_data_byte = 8'b01010101.
- Frames 0x00 then 0xFF back-to-back with no idle gap. Required: two done pulses, bytes 0x00 then 0xFF.
- 2 µs low glitch on an idle line. Required: no done pulse, o_data_byte unchanged.
- Frame 0xA3 with stop bit low. Required: no done pulse, o_data_byte keeps its previous value. With UART_RX_FRAMING_ERR_EN defined, o_framing_error pulses once.
- Assert i_reset during data bit 4 of frame 0x3C, then send 0xC5. Required: o_data_byte=0 after reset, then 0xC5 with one done pulse.
- Frame 0x96 sent at 9600 baud ±2.5 %. Required: received correctly.
